// File: rtl/analog_status_pkg.sv
// Shared register map, control bit positions, APB FSM states and response
// payload for the analog status register bank.
package analog_status_pkg;

  localparam int unsigned APB_ADDR_W = 16;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = 4;

  localparam logic [APB_ADDR_W-1:0] STATUS_BASE  = 16'h0000;
  localparam logic [APB_ADDR_W-1:0] CTRL_OFS     = 16'h0100;
  localparam logic [APB_ADDR_W-1:0] CHANGED_OFS  = 16'h0104;
  localparam logic [APB_ADDR_W-1:0] IRQ_MASK_OFS = 16'h0108;
  localparam logic [APB_ADDR_W-1:0] INFO_OFS     = 16'h010C;

  localparam int unsigned CTRL_SNAP_BIT = 0;
  localparam int unsigned CTRL_LIVE_BIT = 1;

  typedef enum logic {
    APB_IDLE = 1'b0,
    APB_RESP = 1'b1
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] prdata;
    logic                  pslverr;
  } apb_rsp_t;

endpackage

// File: rtl/analog_status_bank_if.sv
// APB slave bus bundle for the analog status register bank.
interface analog_status_bank_if;
  import analog_status_pkg::*;

  logic [APB_ADDR_W-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_STRB_W-1:0] PSTRB;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/analog_status_bank_status_sync.sv
// Multi-stage flop synchroniser for one asynchronous status word.
module status_sync #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/analog_status_bank.sv
// APB status bank: synchronised analog status words, atomic snapshot, and
// (with ANALOG_STATUS_CHG_IRQ_EN) sticky change flags with a maskable irq.
module analog_status_bank
  import analog_status_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  analog_status_bank_if.slave      apb,
  input  logic [NUM_CH*DATA_W-1:0] status_in,
  output logic                     irq_o
);

  apb_state_e            state_q, state_d;
  apb_rsp_t              rsp_q, rsp_d;
  logic                  pready_q, pready_d;
  logic                  live_q, live_d;
  logic                  snap_c;
  logic                  hit_c, ro_c, err_c;
  logic [APB_DATA_W-1:0] rd_data_c;
  logic [APB_ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0]     sync   [NUM_CH];
  logic [DATA_W-1:0]     snap_q [NUM_CH];
  logic                  unused_bits;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    status_sync #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .d       (status_in[g*DATA_W +: DATA_W]),
      .q       (sync[g])
    );
  end

  assign word_addr   = {apb.PADDR[APB_ADDR_W-1:2], 2'b00};
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

`ifdef ANALOG_STATUS_CHG_IRQ_EN
  logic [NUM_CH-1:0] changed_q, mask_q, mask_d, w1c_c, set_c;
  logic [DATA_W-1:0] sync_prev_q [NUM_CH];
  logic              irq_q;

  always_comb begin
    set_c = '0;
    for (int i = 0; i < NUM_CH; i++) set_c[i] = (sync[i] != sync_prev_q[i]);
  end

  // A set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) sync_prev_q[i] <= '0;
      changed_q <= '0;
      mask_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) sync_prev_q[i] <= sync[i];
      changed_q <= (changed_q & ~w1c_c) | set_c;
      mask_q    <= mask_d;
      irq_q     <= |(changed_q & mask_q);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_n) state_q <= APB_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    pready_d       = 1'b0;
    rsp_d.prdata   = rsp_q.prdata;
    rsp_d.pslverr  = 1'b0;
    live_d         = live_q;
    snap_c         = 1'b0;
    hit_c          = 1'b0;
    ro_c           = 1'b0;
    err_c          = 1'b0;
    rd_data_c      = '0;
`ifdef ANALOG_STATUS_CHG_IRQ_EN
    mask_d         = mask_q;
    w1c_c          = '0;
`endif

    // Address decode and read mux
    if (word_addr[APB_ADDR_W-1:8] == STATUS_BASE[APB_ADDR_W-1:8]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (word_addr[7:2] == 6'(i)) begin
          hit_c     = 1'b1;
          ro_c      = 1'b1;
          rd_data_c = APB_DATA_W'(live_q ? sync[i] : snap_q[i]);
        end
      end
    end else begin
      case (word_addr)
        CTRL_OFS: begin
          hit_c                    = 1'b1;
          rd_data_c[CTRL_LIVE_BIT] = live_q;
        end
        INFO_OFS: begin
          hit_c     = 1'b1;
          ro_c      = 1'b1;
          rd_data_c = {16'h0000, 8'(DATA_W), 8'(NUM_CH)};
        end
`ifdef ANALOG_STATUS_CHG_IRQ_EN
        CHANGED_OFS: begin
          hit_c     = 1'b1;
          rd_data_c = APB_DATA_W'(changed_q);
        end
        IRQ_MASK_OFS: begin
          hit_c     = 1'b1;
          rd_data_c = APB_DATA_W'(mask_q);
        end
`endif
        default: ;
      endcase
    end

    err_c = !hit_c || (apb.PWRITE && (ro_c || (apb.PSTRB != 4'hF)));

    case (state_q)
      APB_IDLE: begin
        if (apb.PSEL && apb.PENABLE) begin
          state_d       = APB_RESP;
          pready_d      = 1'b1;
          rsp_d.prdata  = (err_c || apb.PWRITE) ? 32'h0 : rd_data_c;
          rsp_d.pslverr = err_c;
          if (apb.PWRITE && !err_c) begin
            case (word_addr)
              CTRL_OFS: begin
                live_d = apb.PWDATA[CTRL_LIVE_BIT];
                snap_c = apb.PWDATA[CTRL_SNAP_BIT];
              end
`ifdef ANALOG_STATUS_CHG_IRQ_EN
              CHANGED_OFS:  w1c_c  = apb.PWDATA[NUM_CH-1:0];
              IRQ_MASK_OFS: mask_d = apb.PWDATA[NUM_CH-1:0];
`endif
              default: ;
            endcase
          end
        end
      end
      APB_RESP: state_d = APB_IDLE;
      default:  state_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      pready_q <= 1'b0;
      rsp_q    <= '0;
      live_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
    end else begin
      pready_q <= pready_d;
      rsp_q    <= rsp_d;
      live_q   <= live_d;
      if (snap_c) begin
        for (int i = 0; i < NUM_CH; i++) snap_q[i] <= sync[i];
      end
    end
  end

  assign apb.PRDATA  = rsp_q.prdata;
  assign apb.PSLVERR = rsp_q.pslverr;
  assign apb.PREADY  = pready_q;

endmodule

// File: doc/analog_status_bank.md
# analog_status_bank

Parametrised APB status-register bank for the analog subsystem; the successor to the fixed four-word status array. It synchronises NUM_CH analog status words into the clk_in domain and captures all channels atomically on a snapshot command. It detects per-channel changes into sticky W1C flags and raises a maskable interrupt. It sits on the SoC APB fabric next to the analog control registers.

## Interface
- NUM_CH, 4, number of status channels, 1..32
- DATA_W, 32, bits per channel, 1..32; read data zero-extended to 32
- SYNC_STAGES, 2, synchroniser depth per channel, 2..4
- clk_in  input  1  sole clock
- reset_n  input  1  reset, synchronous, active-low
- PADDR  input  16  APB byte address; bits [1:0] ignored
- PSEL / PENABLE / PWRITE  input  1  APB control
- PSTRB  input  4  byte strobes
- PWDATA  input  32  write data
- PRDATA  output  32  read data
- PREADY  output  1  transfer complete
- PSLVERR  output  1  transfer error, valid with PREADY
- status_in  input  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]; asynchronous to clk_in
- irq_o  output  1  level interrupt, registered

## Operation
- Register map (byte offsets):
  - 0x000+4*i STATUS[i], i<NUM_CH: RO. Returns snapshot[i], or live synced value when CTRL.LIVE=1.
  - 0x100 CTRL: bit0 SNAP (write 1 = capture all synced channels into snapshot; reads 0), bit1 LIVE (RW).
  - 0x104 CHANGED: bit i sticky, W1C.
  - 0x108 IRQ_MASK: RW, NUM_CH bits.
  - 0x10C INFO: RO, {16'h0, DATA_W[7:0], NUM_CH[7:0]}.
- Error (PSLVERR=1, no side effect, PRDATA=0) on:
  - unmapped address, including STATUS[i] with i>=NUM_CH;
  - write to STATUS or INFO;
  - write with PSTRB != 4'hF.
- Write responses return PRDATA=0.
- Change detect: sync_prev[i] <= sync[i] each cycle. CHANGED[i] sets when sync[i] != sync_prev[i].
- Set beats W1C in the same cycle.
- irq_o <= |(CHANGED & IRQ_MASK).
- A SNAP in the same cycle as an input change captures the sync value present in that cycle.

## Timing
- APB FSM has two states, IDLE and RESP.
  - IDLE: when PSEL&PENABLE, decode and perform side effects at this edge. Load PRDATA/PSLVERR, set PREADY=1, go to RESP.
  - RESP: PREADY=1 for exactly one cycle, then PREADY=0 and return to IDLE regardless of PSEL.
- Every transfer is setup cycle + 2 access cycles (one wait state). Back-to-back transfers are supported.
- PRDATA holds its last value outside responses.
- Latency from a status_in change (stable before edge 0):
  - live read value visible after edge SYNC_STAGES-1;
  - CHANGED set at edge SYNC_STAGES;
  - irq_o high at edge SYNC_STAGES+1.
- Reset values, asserted at any clk_in edge with reset_n=0 (including mid-transfer):
  - PREADY=0, PSLVERR=0, PRDATA=0, irq_o=0;
  - FSM to IDLE;
  - sync chains, sync_prev, snapshot, CHANGED, IRQ_MASK, CTRL all 0.
- sync_prev resets to 0, so a nonzero input after reset sets CHANGED once. This is intended.

## Configuration
- ANALOG_STATUS_CHG_IRQ_EN defined: change detection, CHANGED, IRQ_MASK and irq_o behave as above.
- Undefined: no change-detect logic is built.
  - 0x104 and 0x108 return PSLVERR on read and write.
  - irq_o is tied 0.
  - INFO, snapshot and LIVE are unaffected.

## Structure
- Package analog_status_pkg holds:
  - register offset localparams (STATUS_BASE, CTRL_OFS, CHANGED_OFS, IRQ_MASK_OFS, INFO_OFS);
  - CTRL bit indices;
  - the APB FSM state enum.
- Sub-module status_sync: one DATA_W-wide, SYNC_STAGES-deep flop chain with synchronous active-low reset, instantiated per channel by a generate loop.

## Test plan
- Reset: hold reset_n=0 over 3 edges mid-read -> PREADY=0, PRDATA=0, irq_o=0; after release, INFO reads 0x0000_2004 (defaults).
- Snapshot: status_in ch2=0xA5A5_0001, write CTRL=1, change ch2 to 0x1234, read 0x008 -> 0xA5A5_0001. Set LIVE (CTRL=2), read 0x008 -> 0x0000_1234.
- Errors: read 0x010 (NUM_CH=4) -> PSLVERR=1, PRDATA=0. Write 0x000 -> PSLVERR=1. Write IRQ_MASK with PSTRB=4'h3 -> PSLVERR=1, mask unchanged.
- Interrupt: IRQ_MASK=0x2, toggle ch1 -> CHANGED=0x2 at edge SYNC_STAGES and irq_o=1 one edge later. Write CHANGED=0x2 -> irq_o=0.
- Simultaneous: W1C CHANGED bit0 in the same cycle ch0's synced value changes -> bit0 remains 1.
- Timing: back-to-back reads -> each shows PREADY high exactly one cycle after PSEL&PENABLE; build with macro undefined -> 0x104 read errors, irq_o stays 0.
